// File: rtl/vram_fill_dma.sv
// vram_fill_dma: register-programmed fill engine for the tile/colour RAMs.
// CPU VRAM cycles always win; the fill steals only idle port cycles.
module vram_fill_dma #(
    parameter logic [15:0] REG_BASE = 16'h9800,
    parameter logic [15:0] VRAM_LO  = 16'h8000,
    parameter logic [15:0] VRAM_HI  = 16'h97FF
) (
    input  logic        clk_sys,
    input  logic        reset_n,
    input  logic [15:0] cpu_addr,
    input  logic [7:0]  cpu_dout,
    input  logic        cpu_wr_n,
    input  logic        cpu_mreq_n,
    output logic        reg_cs,
    output logic [7:0]  reg_dout,
    output logic [10:0] vram_addr,
    output logic [7:0]  vram_data,
    output logic        chram_we,
    output logic        fgcolram_we,
    output logic        bgcolram_we,
    output logic        busy,
    output logic        done
);

    typedef enum logic {IDLE, RUN} state_t;

    state_t      state_q, state_d;
    logic        wr_prev_q, wr_prev_d;
    logic [10:0] addr_q, addr_d;
    logic [11:0] len_q, len_d;
    logic [7:0]  value_q, value_d;
    logic [2:0]  tgt_q, tgt_d;
    logic [10:0] waddr_q, waddr_d;
    logic [11:0] wcnt_q, wcnt_d;
    logic [7:0]  wval_q, wval_d;
    logic [2:0]  wtgt_q, wtgt_d;
    logic        done_q, done_d;
    logic        sticky_q, sticky_d;

    logic [2:0] off;
    logic       cpu_wr;
    logic       strobe;
    logic       go;
    logic       abort;
    logic       stat_wr;
    logic       vram_hit;
    logic       dma_wr;
    logic       in_ch;
    logic       in_fg;
    logic       in_bg;

    assign off      = cpu_addr[2:0];
    assign reg_cs   = (cpu_addr >= REG_BASE) &&
                      (cpu_addr <= REG_BASE + 16'd7);
    assign cpu_wr   = !cpu_wr_n && !cpu_mreq_n;
    assign strobe   = cpu_wr && reg_cs && wr_prev_q;
    assign go       = strobe && (off == 3'd6) && !cpu_dout[7];
    assign abort    = strobe && (off == 3'd6) && cpu_dout[7];
    assign stat_wr  = strobe && (off == 3'd7);
    assign vram_hit = !cpu_mreq_n && (cpu_addr >= VRAM_LO) &&
                      (cpu_addr <= VRAM_HI);
    assign dma_wr   = (state_q == RUN) && !vram_hit;

    assign in_ch = (cpu_addr >= VRAM_LO) &&
                   (cpu_addr < VRAM_LO + 16'h0800);
    assign in_fg = (cpu_addr >= VRAM_LO + 16'h0800) &&
                   (cpu_addr < VRAM_LO + 16'h1000);
    assign in_bg = (cpu_addr >= VRAM_LO + 16'h1000) &&
                   (cpu_addr < VRAM_LO + 16'h1800);

    assign busy = (state_q == RUN);
    assign done = done_q;

    // Port-A mux: fill data on free RUN cycles, CPU passthrough otherwise.
    always_comb begin
        if (dma_wr) begin
            vram_addr   = waddr_q;
            vram_data   = wval_q;
            chram_we    = wtgt_q[0];
            fgcolram_we = wtgt_q[1];
            bgcolram_we = wtgt_q[2];
        end else begin
            vram_addr   = cpu_addr[10:0];
            vram_data   = cpu_dout;
            chram_we    = cpu_wr && in_ch;
            fgcolram_we = cpu_wr && in_fg;
            bgcolram_we = cpu_wr && in_bg;
        end
    end

    // Register readback, decoded purely from the low address bits.
    always_comb begin
        case (off)
            3'd0:    reg_dout = addr_q[7:0];
            3'd1:    reg_dout = {5'b0, addr_q[10:8]};
            3'd2:    reg_dout = len_q[7:0];
            3'd3:    reg_dout = {4'b0, len_q[11:8]};
            3'd4:    reg_dout = value_q;
            3'd5:    reg_dout = {5'b0, tgt_q};
            3'd7:    reg_dout = {6'b0, sticky_q, busy};
            default: reg_dout = 8'h00;
        endcase
    end

    // Next-state: register file, working copies and the IDLE/RUN FSM.
    always_comb begin
        state_d   = state_q;
        wr_prev_d = cpu_wr_n;
        addr_d    = addr_q;
        len_d     = len_q;
        value_d   = value_q;
        tgt_d     = tgt_q;
        waddr_d   = waddr_q;
        wcnt_d    = wcnt_q;
        wval_d    = wval_q;
        wtgt_d    = wtgt_q;
        done_d    = 1'b0;
        sticky_d  = sticky_q;
        if (strobe) begin
            case (off)
                3'd0:    addr_d[7:0]  = cpu_dout;
                3'd1:    addr_d[10:8] = cpu_dout[2:0];
                3'd2:    len_d[7:0]   = cpu_dout;
                3'd3:    len_d[11:8]  = cpu_dout[3:0];
                3'd4:    value_d      = cpu_dout;
                3'd5:    tgt_d        = cpu_dout[2:0];
                default: ;
            endcase
        end
        case (state_q)
            IDLE: begin
                if (go) begin
                    waddr_d = addr_q;
                    wcnt_d  = len_q;
                    wval_d  = value_q;
                    wtgt_d  = tgt_q;
                    if (len_q != 12'd0 && tgt_q != 3'd0) begin
                        state_d = RUN;
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end
            RUN: begin
                if (dma_wr) begin
                    waddr_d = waddr_q + 11'd1;
                    wcnt_d  = wcnt_q - 12'd1;
                end
                // Abort and the final write may coincide: one done only.
                if ((dma_wr && wcnt_q == 12'd1) || abort) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
        if (stat_wr) begin
            sticky_d = 1'b0;
        end
        if (done_d) begin
            sticky_d = 1'b1;
        end
    end

    // State registers; reset also kills any fill in flight.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            wr_prev_q <= 1'b1;
            addr_q    <= '0;
            len_q     <= '0;
            value_q   <= '0;
            tgt_q     <= '0;
            waddr_q   <= '0;
            wcnt_q    <= '0;
            wval_q    <= '0;
            wtgt_q    <= '0;
            done_q    <= 1'b0;
            sticky_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            wr_prev_q <= wr_prev_d;
            addr_q    <= addr_d;
            len_q     <= len_d;
            value_q   <= value_d;
            tgt_q     <= tgt_d;
            waddr_q   <= waddr_d;
            wcnt_q    <= wcnt_d;
            wval_q    <= wval_d;
            wtgt_q    <= wtgt_d;
            done_q    <= done_d;
            sticky_q  <= sticky_d;
        end
    end

endmodule
